// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core front end: PC sequencer states,
// reset vector default and word-alignment helpers.
package mips_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } pc_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [1:0]  WORD_ALIGN_BITS  = 2'b00;
  localparam logic [31:0] WORD_BYTES       = 32'd4;

  // Force an address onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], WORD_ALIGN_BITS};
  endfunction

endpackage

// File: rtl/pc_target_calc.sv
// Combinational redirect-target generation for branch, jump and jr, plus
// detection of a jr target that is not word aligned.
module pc_target_calc
  import mips_pkg::*;
(
  input  logic [31:0] branch_pc4,
  input  logic [31:0] branch_imm,
  input  logic [31:0] jump_pc4,
  input  logic [25:0] jump_index,
  input  logic [31:0] jr_target_raw,
  output logic [31:0] branch_target,
  output logic [31:0] jump_target,
  output logic [31:0] jr_target,
  output logic        jr_misalign
);

  // Only the region bits of the jump's PC+4 select the target segment.
  logic [27:0] unused_jump_pc4;
  assign unused_jump_pc4 = jump_pc4[27:0];

  // Target arithmetic; all sums wrap modulo 2^32.
  always_comb begin
    branch_target = branch_pc4 + (branch_imm << 2);
    jump_target   = {jump_pc4[31:28], jump_index, WORD_ALIGN_BITS};
    jr_target     = word_align(jr_target_raw);
    jr_misalign   = (jr_target_raw[1:0] != WORD_ALIGN_BITS);
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner for the pipelined MIPS core: boot bubbles, next-PC
// selection, hazard stalls, flush generation and performance counters.
module pc_sequencer
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = RESET_PC_DEFAULT,
  parameter int unsigned BOOT_BUBBLES  = 1,
  parameter int unsigned STALL_TIMEOUT = 64,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_i,
  input  logic             branch_i,
  input  logic [31:0]      branch_pc4_i,
  input  logic [31:0]      branch_imm_i,
  input  logic             jump_i,
  input  logic [31:0]      jump_pc4_i,
  input  logic [25:0]      jump_index_i,
  input  logic             jr_i,
  input  logic [31:0]      jr_target_i,
  output logic [31:0]      pc_o,
  output logic [31:0]      pc4_o,
  output logic             fetch_valid_o,
  output logic             flush_if_o,
  output logic             flush_id_o,
  output logic             misalign_o,
  output logic             stall_timeout_o,
  output logic [CNT_W-1:0] redirect_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam logic [3:0]          BOOT_LAST = 4'(BOOT_BUBBLES - 1);
  localparam int unsigned         RUN_W     = $clog2(STALL_TIMEOUT + 1);
  localparam logic [RUN_W-1:0]    RUN_MAX   = RUN_W'(STALL_TIMEOUT);

  pc_state_e        state;
  logic [3:0]       boot_cnt;
  logic [RUN_W-1:0] stall_run;

  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] jr_target;
  logic        jr_misalign;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        in_boot;

  pc_target_calc u_target (
    .branch_pc4    (branch_pc4_i),
    .branch_imm    (branch_imm_i),
    .jump_pc4      (jump_pc4_i),
    .jump_index    (jump_index_i),
    .jr_target_raw (jr_target_i),
    .branch_target (branch_target),
    .jump_target   (jump_target),
    .jr_target     (jr_target),
    .jr_misalign   (jr_misalign)
  );

  // Redirect priority (jr > branch > jump), flushes and sequential address.
  always_comb begin
    redirect = jr_i | branch_i | jump_i;
    if (jr_i) begin
      redirect_pc = jr_target;
    end else if (branch_i) begin
      redirect_pc = branch_target;
    end else begin
      redirect_pc = jump_target;
    end
    in_boot    = (state == ST_BOOT);
    flush_if_o = !in_boot && redirect;
    flush_id_o = !in_boot && (jr_i | branch_i);
    pc4_o      = pc_o + WORD_BYTES;
  end

  // FSM, PC register, stall run tracking and saturating counters.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state           <= ST_BOOT;
      boot_cnt        <= '0;
      pc_o            <= RESET_PC;
      fetch_valid_o   <= 1'b0;
      misalign_o      <= 1'b0;
      stall_timeout_o <= 1'b0;
      redirect_cnt_o  <= '0;
      stall_cnt_o     <= '0;
      stall_run       <= '0;
    end else begin
      misalign_o <= 1'b0;
      case (state)
        ST_BOOT: begin
          if (boot_cnt == BOOT_LAST) begin
            state         <= ST_RUN;
            fetch_valid_o <= 1'b1;
          end else begin
            boot_cnt <= boot_cnt + 1'b1;
          end
        end
        default: begin
          // A redirect wins over a pending stall: the stalled instruction is
          // on the wrong path and is flushed anyway.
          if (redirect) begin
            pc_o       <= redirect_pc;
            state      <= ST_RUN;
            stall_run  <= '0;
            misalign_o <= jr_i & jr_misalign;
            if (redirect_cnt_o != '1) begin
              redirect_cnt_o <= redirect_cnt_o + 1'b1;
            end
          end else if (stall_i) begin
            state <= ST_HOLD;
            if (stall_cnt_o != '1) begin
              stall_cnt_o <= stall_cnt_o + 1'b1;
            end
            if (stall_run != RUN_MAX) begin
              stall_run <= stall_run + 1'b1;
            end
            if (stall_run >= RUN_MAX - 1'b1) begin
              stall_timeout_o <= 1'b1;
            end
          end else begin
            pc_o      <= pc4_o;
            state     <= ST_RUN;
            stall_run <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a driver applies one input vector per
// cycle and queues the expected response from a behavioural model; monitors
// pop and compare combinational and registered outputs independently.
`timescale 1ns/1ps
module tb_pc_sequencer;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          TMO    = 64;
  localparam int          BOOT   = 1;
  localparam int          SAT    = 65535;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        stall_i = 1'b0, branch_i = 1'b0, jump_i = 1'b0, jr_i = 1'b0;
  logic [31:0] branch_pc4_i = '0, branch_imm_i = '0, jump_pc4_i = '0, jr_target_i = '0;
  logic [25:0] jump_index_i = '0;
  logic [31:0] pc_o, pc4_o;
  logic        fetch_valid_o, flush_if_o, flush_id_o, misalign_o, stall_timeout_o;
  logic [15:0] redirect_cnt_o, stall_cnt_o;

  always #5 clk = ~clk;

  pc_sequencer #(
    .RESET_PC      (RST_PC),
    .BOOT_BUBBLES  (BOOT),
    .STALL_TIMEOUT (TMO),
    .CNT_W         (16)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .stall_i         (stall_i),
    .branch_i        (branch_i),
    .branch_pc4_i    (branch_pc4_i),
    .branch_imm_i    (branch_imm_i),
    .jump_i          (jump_i),
    .jump_pc4_i      (jump_pc4_i),
    .jump_index_i    (jump_index_i),
    .jr_i            (jr_i),
    .jr_target_i     (jr_target_i),
    .pc_o            (pc_o),
    .pc4_o           (pc4_o),
    .fetch_valid_o   (fetch_valid_o),
    .flush_if_o      (flush_if_o),
    .flush_id_o      (flush_id_o),
    .misalign_o      (misalign_o),
    .stall_timeout_o (stall_timeout_o),
    .redirect_cnt_o  (redirect_cnt_o),
    .stall_cnt_o     (stall_cnt_o)
  );

  typedef struct {
    logic [31:0] pc;
    logic        valid;
    logic        mis;
    logic        tmo;
    int          rc;
    int          sc;
  } reg_exp_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        fif;
    logic        fid;
  } comb_exp_t;

  reg_exp_t  rq[$];
  comb_exp_t cq[$];
  int total = 0;
  int bad   = 0;

  // Behavioural model state.
  logic [31:0] m_pc;
  int          m_boot, m_rc, m_sc, m_run;
  logic        m_valid, m_mis, m_tmo;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_pc = RST_PC; m_boot = BOOT; m_rc = 0; m_sc = 0; m_run = 0;
    m_valid = 1'b0; m_mis = 1'b0; m_tmo = 1'b0;
  endfunction

  // One clock of stimulus; queues expectations for this cycle and the next edge.
  task automatic step(input logic st, input logic br, input logic jp, input logic jr,
                      input logic [31:0] bpc4, input logic [31:0] bimm,
                      input logic [31:0] jpc4, input logic [25:0] jidx,
                      input logic [31:0] jrt);
    comb_exp_t ce;
    reg_exp_t  re;
    @(negedge clk);
    stall_i = st; branch_i = br; jump_i = jp; jr_i = jr;
    branch_pc4_i = bpc4; branch_imm_i = bimm; jump_pc4_i = jpc4;
    jump_index_i = jidx; jr_target_i = jrt;

    ce.pc  = m_pc;
    ce.pc4 = m_pc + 32'd4;
    ce.fif = (m_boot == 0) && (jr || br || jp);
    ce.fid = (m_boot == 0) && (jr || br);
    cq.push_back(ce);

    m_mis = 1'b0;
    if (m_boot > 0) begin
      m_boot--;
      m_valid = (m_boot == 0);
    end else if (jr || br || jp) begin
      if (jr) begin
        m_pc  = jrt & 32'hFFFF_FFFC;
        m_mis = (jrt % 4) != 0;
      end else if (br) begin
        m_pc = bpc4 + bimm * 32'd4;
      end else begin
        m_pc = (jpc4 & 32'hF000_0000) | (32'(jidx) * 32'd4);
      end
      if (m_rc < SAT) m_rc++;
      m_run = 0;
    end else if (st) begin
      if (m_sc < SAT) m_sc++;
      m_run++;
      if (m_run >= TMO) m_tmo = 1'b1;
    end else begin
      m_pc  = m_pc + 32'd4;
      m_run = 0;
    end

    re.pc = m_pc; re.valid = m_valid; re.mis = m_mis; re.tmo = m_tmo;
    re.rc = m_rc; re.sc = m_sc;
    rq.push_back(re);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, '0, '0, '0, '0, '0);
  endtask

  // Pulse reset low for 1 ns away from the clock edge and check it acts at once.
  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_i = 1'b0;
    #0.5;
    chk("rst_pc", pc_o, RST_PC);
    chk("rst_valid", fetch_valid_o, 0);
    chk("rst_mis", misalign_o, 0);
    chk("rst_tmo", stall_timeout_o, 0);
    chk("rst_rcnt", redirect_cnt_o, 0);
    chk("rst_scnt", stall_cnt_o, 0);
    model_reset();
    rq.delete();
    cq.delete();
    #0.5;
    rst_i = 1'b1;
  endtask

  // Registered-output monitor.
  initial begin
    reg_exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rq.size() > 0) begin
        e = rq.pop_front();
        chk("pc", pc_o, e.pc);
        chk("fetch_valid", fetch_valid_o, e.valid);
        chk("misalign", misalign_o, e.mis);
        chk("stall_timeout", stall_timeout_o, e.tmo);
        chk("redirect_cnt", redirect_cnt_o, e.rc);
        chk("stall_cnt", stall_cnt_o, e.sc);
      end
    end
  end

  // Combinational-output monitor.
  initial begin
    comb_exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (cq.size() > 0) begin
        e = cq.pop_front();
        chk("pc_hold", pc_o, e.pc);
        chk("pc4", pc4_o, e.pc4);
        chk("flush_if", flush_if_o, e.fif);
        chk("flush_id", flush_id_o, e.fid);
      end
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic r_st, r_br, r_jp, r_jr;
    model_reset();
    do_reset();

    // Boot bubble then sequential fetch.
    idle(3);
    // Directed redirects.
    step(0, 0, 1, 0, '0, '0, 32'h0000_000C, 26'h10, '0);                // -> 0x40
    step(0, 1, 0, 0, 32'h0000_0040, 32'hFFFF_FFFE, '0, '0, '0);         // -> 0x38
    step(0, 0, 1, 0, '0, '0, 32'h1000_0004, 26'h0000100, '0);           // -> 0x1000_0400
    step(1, 1, 0, 1, 32'h0000_1234, 32'd5, '0, '0, 32'h0000_2003);      // -> 0x2000, misalign
    idle(1);
    step(1, 0, 0, 0, '0, '0, '0, '0, '0);
    step(1, 0, 0, 0, '0, '0, '0, '0, '0);
    idle(1);
    step(0, 0, 0, 1, '0, '0, '0, '0, 32'hFFFF_FFFC);                    // wrap point
    idle(2);

    // Randomized traffic, starting in BOOT so ignored inputs are exercised.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      r_st = ($urandom_range(0, 99) < 30);
      r_br = ($urandom_range(0, 9) == 0);
      r_jp = ($urandom_range(0, 9) == 0);
      r_jr = ($urandom_range(0, 9) == 0);
      step(r_st, r_br, r_jp, r_jr, $urandom, $urandom, $urandom,
           26'($urandom), $urandom);
    end

    // Long stall: timeout trips at the 64th honoured stall, then reset mid-stall.
    do_reset();
    idle(1);
    for (int i = 0; i < 70; i++) step(1, 0, 0, 0, '0, '0, '0, '0, '0);
    do_reset();
    idle(3);

    repeat (2) @(posedge clk);
    #2;
    chk("queue_drain", rq.size() + cq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
